// File: rtl/rx_buff_pkg.sv
// Shared types and helpers for the ordered RX virtual-channel buffer.
package rx_buff_pkg;

    typedef enum logic [1:0] {
        TLP_P    = 2'b00,
        TLP_NP   = 2'b01,
        TLP_RSVD = 2'b10,
        TLP_CPL  = 2'b11
    } tlp_type_t;

    localparam int CREDIT_DW = 4;

    function automatic int seq_width(input int max_tlp);
        return $clog2(3 * max_tlp) + 1;
    endfunction

    // Queue index 0/1/2 -> P/NP/CPL
    function automatic tlp_type_t q_enc(input int idx);
        return (idx == 0) ? TLP_P : (idx == 1) ? TLP_NP : TLP_CPL;
    endfunction

endpackage

// File: rtl/rx_ordered_vc_buff_rx_spec_fifo.sv
// Per-type speculative DW queue with committed-TLP sequence store.
module rx_spec_fifo
    import rx_buff_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int MAX_TLP    = 16,
    parameter int SEQ_W      = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic                      wr_commit,
    input  logic                      wr_hdr_data,
    input  logic [DATA_WIDTH-1:0]     wr_dw,
    input  logic                      flush,
    input  logic [SEQ_W-1:0]          wr_seq,
    input  logic                      rd_en,
    output logic                      head_vld,
    output logic [SEQ_W-1:0]          head_seq,
    output logic [DATA_WIDTH-1:0]     rd_dw,
    output logic                      rd_hdr_data,
    output logic                      rd_last,
    output logic                      wr_drop,
    output logic                      cmt_ok,
    output logic [$clog2(DEPTH):0]    free_dw,
    output logic [$clog2(MAX_TLP):0]  free_tlp
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(MAX_TLP);

    logic [DATA_WIDTH+1:0] mem [DEPTH];
    logic [SEQ_W-1:0]      seq_mem [MAX_TLP];

    logic [AW:0] wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d, used_dw;
    logic [TW:0] tw_ptr_q, tw_ptr_d, tr_ptr_q, tr_ptr_d, used_tlp;
    logic        bad_q, bad_d, wr_ok, open_tlp;

    assign used_dw  = wr_ptr_q - rd_ptr_q;
    assign used_tlp = tw_ptr_q - tr_ptr_q;
    assign open_tlp = (wr_ptr_q != cmt_ptr_q);
    assign wr_ok    = wr_en && !used_dw[AW] && !used_tlp[TW];
    assign wr_drop  = wr_en && !wr_ok;
    assign cmt_ok   = wr_en && wr_commit && wr_ok && !bad_q && !flush;
    assign head_vld = (used_tlp != '0);
    assign head_seq = seq_mem[tr_ptr_q[TW-1:0]];
    assign free_dw  = (AW+1)'(DEPTH) - used_dw;
    assign free_tlp = (TW+1)'(MAX_TLP) - used_tlp - {{TW{1'b0}}, open_tlp};

    assign {rd_hdr_data, rd_last, rd_dw} = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        cmt_ptr_d = cmt_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tw_ptr_d  = tw_ptr_q;
        tr_ptr_d  = tr_ptr_q;
        bad_d     = bad_q;
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (rd_last)
                tr_ptr_d = tr_ptr_q + 1'b1;
        end
        if (flush) begin
            wr_ptr_d = cmt_ptr_q;
            bad_d    = 1'b0;
        end else if (wr_en) begin
            if (wr_ok)
                wr_ptr_d = wr_ptr_q + 1'b1;
            else
                bad_d = 1'b1;
            // A TLP that lost any DW is rolled back at its commit
            if (wr_commit) begin
                bad_d = 1'b0;
                if (cmt_ok) begin
                    cmt_ptr_d = wr_ptr_q + 1'b1;
                    tw_ptr_d  = tw_ptr_q + 1'b1;
                end else begin
                    wr_ptr_d = cmt_ptr_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            rd_ptr_q  <= '0;
            tw_ptr_q  <= '0;
            tr_ptr_q  <= '0;
            bad_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tw_ptr_q  <= tw_ptr_d;
            tr_ptr_q  <= tr_ptr_d;
            bad_q     <= bad_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !flush)
            mem[wr_ptr_q[AW-1:0]] <= {wr_hdr_data, wr_commit, wr_dw};
        if (cmt_ok)
            seq_mem[tw_ptr_q[TW-1:0]] <= wr_seq;
    end

endmodule

// File: rtl/rx_ordered_vc_buff.sv
// Ordered RX VC buffer: three speculative type queues, age arbiter, credits.
module rx_ordered_vc_buff
    import rx_buff_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int MAX_TLP    = 16,
    parameter int CREDIT_W   = 10,
    parameter int BYPASS_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [1:0]            wr_type,
    input  logic                  wr_hdr_data,
    input  logic [DATA_WIDTH-1:0] wr_dw,
    input  logic                  wr_commit,
    input  logic                  wr_flush,
    input  logic                  np_stall,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_dw,
    output logic [1:0]            rd_type,
    output logic                  rd_hdr_data,
    output logic                  rd_last,
    output logic [CREDIT_W-1:0]   p_h_credit,
    output logic [CREDIT_W-1:0]   p_d_credit,
    output logic [CREDIT_W-1:0]   np_h_credit,
    output logic [CREDIT_W-1:0]   np_d_credit,
    output logic [CREDIT_W-1:0]   cpl_h_credit,
    output logic [CREDIT_W-1:0]   cpl_d_credit,
    output logic                  err_ovf,
    output logic                  empty
);

    localparam int SEQ_W = seq_width(MAX_TLP);

    typedef enum logic {RD_IDLE, RD_LOCK} rd_state_t;

    rd_state_t              state_q, state_d;
    logic [1:0]             lock_q, lock_d, sel, pick;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic                   err_q, err_d, pick_vld, vld_c;
    logic [2:0]             q_wr, q_vld, q_rd, q_drop, q_cmt, q_hdr, q_last, elig;
    logic [SEQ_W-1:0]       q_seq [3];
    logic [DATA_WIDTH-1:0]  q_dw [3];
    logic [$clog2(DEPTH):0]   q_free_dw [3];
    logic [$clog2(MAX_TLP):0] q_free_tlp [3];
    logic [CREDIT_W-1:0]    hc [3];
    logic [CREDIT_W-1:0]    dc [3];

    function automatic logic older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] d;
        d = a - b;
        return d[SEQ_W-1];
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_q
        assign q_wr[i] = wr_valid && !wr_flush && (wr_type == q_enc(i));
        assign hc[i]   = CREDIT_W'(q_free_tlp[i]);
        assign dc[i]   = CREDIT_W'(q_free_dw[i] >> $clog2(CREDIT_DW));

        rx_spec_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .MAX_TLP    (MAX_TLP),
            .SEQ_W      (SEQ_W)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst),
            .wr_en       (q_wr[i]),
            .wr_commit   (wr_commit),
            .wr_hdr_data (wr_hdr_data),
            .wr_dw       (wr_dw),
            .flush       (wr_flush),
            .wr_seq      (seq_q),
            .rd_en       (q_rd[i]),
            .head_vld    (q_vld[i]),
            .head_seq    (q_seq[i]),
            .rd_dw       (q_dw[i]),
            .rd_hdr_data (q_hdr[i]),
            .rd_last     (q_last[i]),
            .wr_drop     (q_drop[i]),
            .cmt_ok      (q_cmt[i]),
            .free_dw     (q_free_dw[i]),
            .free_tlp    (q_free_tlp[i])
        );
    end

    // Oldest committed head wins; a stalled NP is skipped or blocks all
    always_comb begin
        elig     = q_vld;
        pick     = 2'd0;
        pick_vld = 1'b0;
        if (BYPASS_EN != 0 && np_stall)
            elig[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (elig[i] && (!pick_vld || older(q_seq[i], q_seq[pick]))) begin
                pick     = 2'(i);
                pick_vld = 1'b1;
            end
        end
        if (BYPASS_EN == 0 && np_stall && pick == 2'd1)
            pick_vld = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        sel     = lock_q;
        vld_c   = 1'b0;
        q_rd    = '0;
        unique case (state_q)
            RD_IDLE: begin
                sel   = pick;
                vld_c = pick_vld;
            end
            RD_LOCK: begin
                sel   = lock_q;
                vld_c = 1'b1;
            end
        endcase
        if (vld_c && rd_ready) begin
            q_rd[sel] = 1'b1;
            if (q_last[sel]) begin
                state_d = RD_IDLE;
            end else begin
                state_d = RD_LOCK;
                lock_d  = sel;
            end
        end
    end

    assign seq_d = seq_q + {{(SEQ_W-1){1'b0}}, |q_cmt};
    assign err_d = wr_valid && !wr_flush && (wr_type == TLP_RSVD || |q_drop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RD_IDLE;
            lock_q  <= '0;
            seq_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
        end
    end

    assign rd_valid     = vld_c;
    assign rd_dw        = vld_c ? q_dw[sel] : '0;
    assign rd_type      = vld_c ? q_enc(sel) : TLP_P;
    assign rd_hdr_data  = vld_c && q_hdr[sel];
    assign rd_last      = vld_c && q_last[sel];
    assign err_ovf      = err_q;
    assign empty        = ~|q_vld;
    assign p_h_credit   = hc[0];
    assign p_d_credit   = dc[0];
    assign np_h_credit  = hc[1];
    assign np_d_credit  = dc[1];
    assign cpl_h_credit = hc[2];
    assign cpl_d_credit = dc[2];

endmodule

// File: tb/tb_rx_ordered_vc_buff.sv
// Randomized + directed bench for rx_ordered_vc_buff against a queue model.
module tb_rx_ordered_vc_buff;

    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int MAXT  = 16;
    localparam int CW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_valid = 1'b0, wr_hdr_data = 1'b0, wr_commit = 1'b0;
    logic          wr_flush = 1'b0, np_stall = 1'b0, rd_ready = 1'b0;
    logic [1:0]    wr_type = 2'b00;
    logic [DW-1:0] wr_dw = '0;

    logic [1:0]    rd_valid, rd_hdr, rd_last, err_ovf, empty;
    logic [DW-1:0] rd_dw [2];
    logic [1:0]    rd_type [2];
    logic [CW-1:0] hcr [2][3];
    logic [CW-1:0] dcr [2][3];

    always #5 clk = ~clk;

    rx_ordered_vc_buff #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_TLP(MAXT),
        .CREDIT_W(CW), .BYPASS_EN(1)) u_dut0 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_type(wr_type),
        .wr_hdr_data(wr_hdr_data), .wr_dw(wr_dw), .wr_commit(wr_commit),
        .wr_flush(wr_flush), .np_stall(np_stall), .rd_ready(rd_ready),
        .rd_valid(rd_valid[0]), .rd_dw(rd_dw[0]), .rd_type(rd_type[0]),
        .rd_hdr_data(rd_hdr[0]), .rd_last(rd_last[0]),
        .p_h_credit(hcr[0][0]), .p_d_credit(dcr[0][0]),
        .np_h_credit(hcr[0][1]), .np_d_credit(dcr[0][1]),
        .cpl_h_credit(hcr[0][2]), .cpl_d_credit(dcr[0][2]),
        .err_ovf(err_ovf[0]), .empty(empty[0]));

    rx_ordered_vc_buff #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_TLP(MAXT),
        .CREDIT_W(CW), .BYPASS_EN(0)) u_dut1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_type(wr_type),
        .wr_hdr_data(wr_hdr_data), .wr_dw(wr_dw), .wr_commit(wr_commit),
        .wr_flush(wr_flush), .np_stall(np_stall), .rd_ready(rd_ready),
        .rd_valid(rd_valid[1]), .rd_dw(rd_dw[1]), .rd_type(rd_type[1]),
        .rd_hdr_data(rd_hdr[1]), .rd_last(rd_last[1]),
        .p_h_credit(hcr[1][0]), .p_d_credit(dcr[1][0]),
        .np_h_credit(hcr[1][1]), .np_d_credit(dcr[1][1]),
        .cpl_h_credit(hcr[1][2]), .cpl_d_credit(dcr[1][2]),
        .err_ovf(err_ovf[1]), .empty(empty[1]));

    // Model per instance m and type t lives at index m*3+t
    logic [33:0] cq [6][$];
    logic [33:0] sq [6][$];
    int          tq [6][$];
    bit          bad [6];
    int          seq_ctr [2];
    int          lock [2];
    bit          err_exp [2];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int enc(input int t);
        return (t == 0) ? 0 : (t == 1) ? 1 : 3;
    endfunction

    function automatic int tidx(input logic [1:0] ty);
        return (ty == 2'b00) ? 0 : (ty == 2'b01) ? 1 : (ty == 2'b11) ? 2 : -1;
    endfunction

    function automatic int exp_sel(input int m);
        int best;
        best = -1;
        if (lock[m] >= 0)
            return lock[m];
        for (int t = 0; t < 3; t++) begin
            if (tq[m*3+t].size() == 0) continue;
            if (m == 0 && np_stall && t == 1) continue;
            if (best < 0 || tq[m*3+t][0] < tq[m*3+best][0])
                best = t;
        end
        if (m == 1 && np_stall && best == 1)
            best = -1;
        return best;
    endfunction

    task automatic mreset(input int m);
        for (int t = 0; t < 3; t++) begin
            cq[m*3+t].delete();
            sq[m*3+t].delete();
            tq[m*3+t].delete();
            bad[m*3+t] = 1'b0;
        end
        seq_ctr[m] = 0;
        lock[m]    = -1;
        err_exp[m] = 1'b0;
    endtask

    task automatic compare(input int m);
        int s, k, h, d;
        s = exp_sel(m);
        chk($sformatf("rd_valid%0d", m), 64'(rd_valid[m]), 64'(s >= 0));
        if (s >= 0) begin
            chk($sformatf("rd_word%0d", m), 64'({rd_hdr[m], rd_last[m], rd_dw[m]}), 64'(cq[m*3+s][0]));
            chk($sformatf("rd_type%0d", m), 64'(rd_type[m]), 64'(enc(s)));
        end else if (!rst) begin
            chk($sformatf("rd_rst%0d", m), 64'({rd_type[m], rd_hdr[m], rd_last[m], rd_dw[m]}), 64'(0));
        end
        for (int t = 0; t < 3; t++) begin
            k = m*3 + t;
            h = MAXT - tq[k].size() - ((sq[k].size() > 0) ? 1 : 0);
            d = (DEPTH - cq[k].size() - sq[k].size()) / 4;
            chk($sformatf("h_credit%0d_%0d", m, t), 64'(hcr[m][t]), 64'(h));
            chk($sformatf("d_credit%0d_%0d", m, t), 64'(dcr[m][t]), 64'(d));
        end
        chk($sformatf("err_ovf%0d", m), 64'(err_ovf[m]), 64'(err_exp[m]));
        chk($sformatf("empty%0d", m), 64'(empty[m]),
            64'(tq[m*3].size() == 0 && tq[m*3+1].size() == 0 && tq[m*3+2].size() == 0));
    endtask

    task automatic update(input int m);
        int s, t, k;
        bit full;
        logic [33:0] e;
        s = exp_sel(m);
        t = tidx(wr_type);
        k = m*3 + ((t < 0) ? 0 : t);
        full = (cq[k].size() + sq[k].size() == DEPTH) || (tq[k].size() == MAXT);
        if (s >= 0 && rd_ready) begin
            e = cq[m*3+s].pop_front();
            if (e[32]) begin
                void'(tq[m*3+s].pop_front());
                lock[m] = -1;
            end else begin
                lock[m] = s;
            end
        end
        err_exp[m] = 1'b0;
        if (wr_flush) begin
            for (int i = 0; i < 3; i++) begin
                sq[m*3+i].delete();
                bad[m*3+i] = 1'b0;
            end
        end else if (wr_valid) begin
            if (t < 0) begin
                err_exp[m] = 1'b1;
            end else begin
                if (full) begin
                    err_exp[m] = 1'b1;
                    bad[k] = 1'b1;
                end else begin
                    sq[k].push_back({wr_hdr_data, wr_commit, wr_dw});
                end
                if (wr_commit) begin
                    if (bad[k]) begin
                        sq[k].delete();
                    end else begin
                        while (sq[k].size() > 0) cq[k].push_back(sq[k].pop_front());
                        tq[k].push_back(seq_ctr[m]);
                        seq_ctr[m]++;
                    end
                    bad[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        #1;
        if (!rst) begin
            mreset(0);
            mreset(1);
        end
        compare(0);
        compare(1);
        if (rst) begin
            update(0);
            update(1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [1:0] ty, input logic hdr, input logic cm);
        wr_valid    = 1'b1;
        wr_type     = ty;
        wr_hdr_data = hdr;
        wr_commit   = cm;
        wr_dw       = $urandom;
        step();
        wr_valid  = 1'b0;
        wr_commit = 1'b0;
    endtask

    task automatic wr_tlp(input logic [1:0] ty, input int nh, input int nd);
        for (int i = 0; i < nh + nd; i++)
            wr(ty, 1'(i >= nh), 1'(i == nh + nd - 1));
    endtask

    initial begin
        int r;
        mreset(0);
        mreset(1);
        @(negedge clk);
        idle(2);
        rst = 1'b1;
        idle(1);

        // P TLP: 3 hdr + 4 data
        rd_ready = 1'b0;
        wr_tlp(2'b00, 3, 4);
        chk("p7_hcr", 64'(hcr[0][0]), 64'(15));
        chk("p7_dcr", 64'(dcr[0][0]), 64'(30));
        rd_ready = 1'b1;
        idle(8);
        chk("p7_dcr_back", 64'(dcr[0][0]), 64'(32));

        // NP partial then flush
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(2'b01, 1'(i > 0), 1'b0);
        chk("np_infl_hcr", 64'(hcr[0][1]), 64'(15));
        wr_flush = 1'b1;
        step();
        wr_flush = 1'b0;
        chk("flush_hcr", 64'(hcr[0][1]), 64'(16));
        chk("flush_dcr", 64'(dcr[0][1]), 64'(32));
        chk("flush_empty", 64'(empty[0]), 64'(1));

        // NP, P, CPL with np_stall: bypass vs. strict order
        np_stall = 1'b1;
        wr_tlp(2'b01, 1, 1);
        wr_tlp(2'b00, 1, 1);
        wr_tlp(2'b11, 1, 1);
        chk("byp_first", 64'(rd_type[0]), 64'(0));
        chk("nobyp_block", 64'(rd_valid[1]), 64'(0));
        rd_ready = 1'b1;
        idle(6);
        chk("byp_np_held", 64'(empty[0]), 64'(0));
        chk("nobyp_held", 64'(rd_valid[1]), 64'(0));
        np_stall = 1'b0;
        idle(8);
        chk("order_drain0", 64'(empty[0]), 64'(1));
        chk("order_drain1", 64'(empty[1]), 64'(1));

        // Fill P to DEPTH, then one more
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr_tlp(2'b00, 4, 12);
        chk("full_dcr", 64'(dcr[0][0]), 64'(0));
        wr(2'b00, 1'b0, 1'b1);
        chk("ovf_pulse", 64'(err_ovf[0]), 64'(1));
        step();
        chk("ovf_clear", 64'(err_ovf[0]), 64'(0));
        rd_ready = 1'b1;
        idle(140);
        chk("full_drain", 64'(empty[0]), 64'(1));

        // Reset mid-read of a CPL TLP
        rd_ready = 1'b0;
        wr_tlp(2'b11, 3, 3);
        rd_ready = 1'b1;
        idle(2);
        chk("mid_read", 64'(rd_valid[0]), 64'(1));
        rst = 1'b0;
        #1;
        chk("rst_now0", 64'(rd_valid[0]), 64'(0));
        chk("rst_now1", 64'(rd_valid[1]), 64'(0));
        @(negedge clk);
        idle(2);
        rst = 1'b1;
        step();
        for (int t = 0; t < 3; t++) begin
            chk("rst_hcr", 64'(hcr[0][t]), 64'(MAXT));
            chk("rst_dcr", 64'(dcr[0][t]), 64'(DEPTH / 4));
        end

        // Random traffic
        repeat (3000) begin
            wr_valid    = 1'($urandom_range(9) < 6);
            r           = int'($urandom_range(15));
            wr_type     = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b11 : 2'b10;
            wr_hdr_data = 1'($urandom_range(1));
            wr_commit   = 1'($urandom_range(5) == 0);
            wr_flush    = 1'($urandom_range(39) == 0);
            wr_dw       = $urandom;
            rd_ready    = 1'($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) np_stall = ~np_stall;
            step();
        end
        wr_valid = 1'b0;
        wr_commit = 1'b0;
        wr_flush = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
